// File: rtl/led_ctrl_pkg.sv
// Shared constants for the memory-mapped LED controller: register word offsets,
// channel mode encodings and common widths.
package led_ctrl_pkg;

   localparam int unsigned OFS_W  = 4;
   localparam int unsigned MODE_W = 2;
   localparam int unsigned PWM_W  = 8;

   localparam logic [OFS_W-1:0] OFS_OUT    = 4'h0;
   localparam logic [OFS_W-1:0] OFS_MODE   = 4'h1;
   localparam logic [OFS_W-1:0] OFS_PRESC  = 4'h2;
   localparam logic [OFS_W-1:0] OFS_DUTY   = 4'h3;
   localparam logic [OFS_W-1:0] OFS_SET    = 4'h4;
   localparam logic [OFS_W-1:0] OFS_CLR    = 4'h5;
   localparam logic [OFS_W-1:0] OFS_STATUS = 4'h6;

   typedef enum logic [MODE_W-1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_PWM    = 2'b10,
      MODE_OFF    = 2'b11
   } led_mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// Shared time base: down-counting prescaler producing a tick, a blink phase
// that toggles per tick and an 8-bit PWM counter advanced per tick.
module led_tick_gen
   import led_ctrl_pkg::*;
#(
   parameter int unsigned PRESC_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PRESC_W-1:0] presc,
   input  logic               reload,
   output logic               tick,
   output logic               phase,
   output logic [PWM_W-1:0]   pwm_cnt
);

   logic [PRESC_W-1:0] presc_cnt;

   assign tick = (presc_cnt == '0);

   // A reload restarts the time base so blink and PWM begin from a known phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         phase     <= 1'b0;
         pwm_cnt   <= '0;
      end else if (reload) begin
         presc_cnt <= presc;
         phase     <= 1'b0;
         pwm_cnt   <= '0;
      end else if (tick) begin
         presc_cnt <= presc;
         phase     <= ~phase;
         pwm_cnt   <= pwm_cnt + PWM_W'(1);
      end else begin
         presc_cnt <= presc_cnt - PRESC_W'(1);
      end
   end

endmodule

// File: rtl/led_ctrl_mm.sv
// Memory-mapped LED controller: register file, registered readback and the
// per-channel static/blink/PWM/off output mux.
module led_ctrl_mm
   import led_ctrl_pkg::*;
#(
   parameter int unsigned       NUM_LED   = 5,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1000_0000),
   parameter int unsigned       PRESC_W   = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  bus_addr,
   input  logic               bus_wr_en,
   input  logic [DATA_W-1:0]  bus_wdata,
   input  logic               bus_rd_en,
   output logic [DATA_W-1:0]  bus_rdata,
   output logic               bus_rvalid,
   output logic [NUM_LED-1:0] led
);

   localparam int unsigned MODE_BITS = MODE_W * NUM_LED;

   logic                 hit_c;
   logic [OFS_W-1:0]     ofs_c;
   logic                 wr_c;
   logic                 presc_wr_c;
   logic [PRESC_W-1:0]   presc_next_c;
   logic [NUM_LED-1:0]   out_q;
   logic [MODE_BITS-1:0] mode_q;
   logic [PRESC_W-1:0]   presc_q;
   logic [PWM_W-1:0]     duty_q;
   logic                 tick;
   logic                 phase;
   logic [PWM_W-1:0]     pwm_cnt;
   logic                 pwm_on_c;
   logic [NUM_LED-1:0]   led_d_c;
   logic [DATA_W-1:0]    rd_word_c;
   logic                 unused_bits_c;

   assign hit_c        = (bus_addr[ADDR_W-1:6] == BASE_ADDR[ADDR_W-1:6]);
   assign ofs_c        = bus_addr[5:2];
   assign wr_c         = bus_wr_en & hit_c;
   assign presc_wr_c   = wr_c & (ofs_c == OFS_PRESC);
   assign presc_next_c = presc_wr_c ? bus_wdata[PRESC_W-1:0] : presc_q;
   assign pwm_on_c     = (pwm_cnt < duty_q);
   assign unused_bits_c = ^{bus_addr[1:0], bus_wdata, tick};

   led_tick_gen #(
      .PRESC_W (PRESC_W)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .presc   (presc_next_c),
      .reload  (presc_wr_c),
      .tick    (tick),
      .phase   (phase),
      .pwm_cnt (pwm_cnt)
   );

   // Register file; SET/CLR act on OUT as write-one-to-set/clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         mode_q  <= '0;
         presc_q <= '0;
         duty_q  <= '0;
      end else if (wr_c) begin
         case (ofs_c)
            OFS_OUT:   out_q   <= bus_wdata[NUM_LED-1:0];
            OFS_MODE:  mode_q  <= bus_wdata[MODE_BITS-1:0];
            OFS_PRESC: presc_q <= bus_wdata[PRESC_W-1:0];
            OFS_DUTY:  duty_q  <= bus_wdata[PWM_W-1:0];
            OFS_SET:   out_q   <= out_q | bus_wdata[NUM_LED-1:0];
            OFS_CLR:   out_q   <= out_q & ~bus_wdata[NUM_LED-1:0];
            default:   ;
         endcase
      end
   end

   // Readback uses pre-write register values; misses read as zero.
   always_comb begin
      rd_word_c = '0;
      if (hit_c) begin
         case (ofs_c)
            OFS_OUT:    rd_word_c[NUM_LED-1:0]   = out_q;
            OFS_MODE:   rd_word_c[MODE_BITS-1:0] = mode_q;
            OFS_PRESC:  rd_word_c[PRESC_W-1:0]   = presc_q;
            OFS_DUTY:   rd_word_c[PWM_W-1:0]     = duty_q;
            OFS_STATUS: begin
               rd_word_c[0]          = phase;
               rd_word_c[8 +: PWM_W] = pwm_cnt;
            end
            default:    rd_word_c = '0;
         endcase
      end
   end

   always_comb begin
      led_d_c = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         case (led_mode_e'(mode_q[MODE_W*i +: MODE_W]))
            MODE_STATIC: led_d_c[i] = out_q[i];
            MODE_BLINK:  led_d_c[i] = out_q[i] & phase;
            MODE_PWM:    led_d_c[i] = out_q[i] & pwm_on_c;
            default:     led_d_c[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
         led        <= '0;
      end else begin
         bus_rdata  <= bus_rd_en ? rd_word_c : '0;
         bus_rvalid <= bus_rd_en;
         led        <= led_d_c;
      end
   end

endmodule

// File: tb/tb_led_ctrl_mm.sv
// Bench for led_ctrl_mm: directed scenarios plus random bus traffic against an
// arithmetic model (ticks since last prescaler reload = cycles / (PRESC+1)).
module tb_led_ctrl_mm;

   localparam int unsigned NL = 5;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   bus_addr;
   logic          bus_wr_en;
   logic [31:0]   bus_wdata;
   logic          bus_rd_en;
   logic [31:0]   bus_rdata;
   logic          bus_rvalid;
   logic [NL-1:0] led;

   int checks = 0;
   int errors = 0;

   logic [NL-1:0]   m_out;
   logic [2*NL-1:0] m_mode;
   int unsigned     m_presc;
   int unsigned     m_duty;
   int unsigned     m_k;
   logic [NL-1:0]   m_led;
   logic [31:0]     m_rdata;
   logic            m_rvalid;

   led_ctrl_mm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_addr   (bus_addr),
      .bus_wr_en  (bus_wr_en),
      .bus_wdata  (bus_wdata),
      .bus_rd_en  (bus_rd_en),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .led        (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_out = '0; m_mode = '0; m_presc = 0; m_duty = 0; m_k = 0;
      m_led = '0; m_rdata = '0; m_rvalid = 1'b0;
   endfunction

   // One clock edge of the reference, from values visible just before the edge.
   function automatic void model_edge();
      int unsigned ticks;
      int unsigned pwm;
      int unsigned ofs;
      logic        ph;
      logic        on;
      logic        sel;
      ticks = m_k / (m_presc + 1);
      ph    = (ticks % 2) == 1;
      pwm   = ticks % 256;
      on    = pwm < m_duty;
      for (int i = 0; i < NL; i++) begin
         case (m_mode[2*i +: 2])
            2'd0:    m_led[i] = m_out[i];
            2'd1:    m_led[i] = m_out[i] & ph;
            2'd2:    m_led[i] = m_out[i] & on;
            default: m_led[i] = 1'b0;
         endcase
      end
      sel = (bus_addr[31:6] == BASE[31:6]);
      ofs = 32'(bus_addr[5:0]) & 32'h3C;
      m_rvalid = bus_rd_en;
      m_rdata  = '0;
      if (bus_rd_en && sel) begin
         case (ofs)
            32'h00: m_rdata = 32'(m_out);
            32'h04: m_rdata = 32'(m_mode);
            32'h08: m_rdata = m_presc;
            32'h0C: m_rdata = m_duty;
            32'h18: m_rdata = (pwm * 256) + (ticks % 2);
            default: m_rdata = '0;
         endcase
      end
      m_k++;
      if (bus_wr_en && sel) begin
         case (ofs)
            32'h00: m_out  = bus_wdata[NL-1:0];
            32'h04: m_mode = bus_wdata[2*NL-1:0];
            32'h08: begin m_presc = bus_wdata & 32'h00FF_FFFF; m_k = 0; end
            32'h0C: m_duty = bus_wdata & 32'hFF;
            32'h10: m_out  = m_out | bus_wdata[NL-1:0];
            32'h14: m_out  = m_out & ~bus_wdata[NL-1:0];
            default: ;
         endcase
      end
   endfunction

   task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
      bus_wr_en = wr; bus_rd_en = rd; bus_addr = addr; bus_wdata = data;
      @(posedge clk);
      model_edge();
      #1;
      check("led", 32'(led), 32'(m_led));
      check("rvalid", 32'(bus_rvalid), 32'(m_rvalid));
      if (m_rvalid) check("rdata", bus_rdata, m_rdata);
      bus_wr_en = 1'b0; bus_rd_en = 1'b0;
   endtask

   task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
      cyc(1'b1, 1'b0, BASE + ofs, data);
   endtask

   task automatic rd(input logic [31:0] addr);
      cyc(1'b0, 1'b1, addr, 32'h0);
   endtask

   initial begin
      int          cnt;
      int unsigned w;
      logic [31:0] a;
      logic [31:0] d;

      rst_n = 1'b0; bus_addr = '0; bus_wr_en = 1'b0; bus_wdata = '0; bus_rd_en = 1'b0;
      model_reset();
      #12;
      check("reset_led", 32'(led), 32'h0);
      check("reset_rvalid", 32'(bus_rvalid), 32'h0);
      check("reset_rdata", bus_rdata, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // static output and readback
      wr(32'h00, 32'h15);
      cyc(1'b0, 1'b0, BASE, 32'h0);
      check("t1_led", 32'(led), 32'h15);
      rd(BASE);
      check("t1_rdata", bus_rdata, 32'h15);

      // channel 0 blinking with period 8
      wr(32'h00, 32'h1F);
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h3);
      cyc(1'b0, 1'b0, BASE, 32'h0);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, (i % 3) == 0, BASE + 32'h18, 32'h0);
         cnt += int'(led[0]);
         check("t2_led_hi", 32'(led[4:1]), 32'hF);
      end
      check("t2_blink_count", cnt, 8);

      // PWM duty 64 of 256, then duty 0
      wr(32'h04, 32'h2);
      wr(32'h08, 32'h0);
      wr(32'h0C, 32'd64);
      cyc(1'b0, 1'b0, BASE, 32'h0);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1'b0, 1'b0, BASE, 32'h0);
         cnt += int'(led[0]);
      end
      check("t3_pwm64_count", cnt, 64);
      wr(32'h0C, 32'd0);
      cyc(1'b0, 1'b0, BASE, 32'h0);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1'b0, 1'b0, BASE, 32'h0);
         cnt += int'(led[0]);
      end
      check("t3_pwm0_count", cnt, 0);

      // set/clear
      wr(32'h04, 32'h0);
      wr(32'h00, 32'h00);
      wr(32'h10, 32'h06);
      wr(32'h14, 32'h02);
      rd(BASE);
      check("t4_out", bus_rdata, 32'h4);
      rd(BASE + 32'h10);
      check("t4_set_rd", bus_rdata, 32'h0);
      rd(BASE + 32'h14);
      check("t4_clr_rd", bus_rdata, 32'h0);

      // unmapped and out-of-window accesses
      wr(32'h3C, 32'hFFFF_FFFF);
      wr(32'h40, 32'hFFFF_FFFF);
      rd(BASE);
      check("t5_out_kept", bus_rdata, 32'h4);
      rd(BASE + 32'h3C);
      check("t5_unmapped_rvalid", 32'(bus_rvalid), 32'h1);
      check("t5_unmapped_rdata", bus_rdata, 32'h0);
      rd(BASE + 32'h40);
      check("t5_nosel_rdata", bus_rdata, 32'h0);

      // random traffic, including simultaneous read/write and ignored upper bits
      for (int n = 0; n < 600; n++) begin
         w = $urandom_range(0, 15);
         a = (($urandom_range(0, 9) == 0) ? BASE + 32'h40 : BASE) + 32'(w * 4) + 32'($urandom_range(0, 3));
         d = $urandom;
         if (w == 2) d = d & 32'hFF00_0007;
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      end

      // asynchronous reset while blinking
      wr(32'h00, 32'h1F);
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h3);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, BASE, 32'h0);
      check("t6_led_before", 32'(led[4:1]), 32'hF);
      #2 rst_n = 1'b0;
      #1;
      check("t6_led_async", 32'(led), 32'h0);
      check("t6_rvalid_async", 32'(bus_rvalid), 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, BASE, 32'h0);
         check("t6_led_after", 32'(led), 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         rd(BASE + 32'(i * 4));
         check("t6_reg_zero", bus_rdata, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_ctrl_mm.md
Name: led_ctrl_mm

Overview:
- Memory-mapped LED controller on the SoC data bus: addr / wr_en / wdata, plus a read port.
- Parametrised successor of the fixed 5-bit LED write register.
- Adds per-channel modes (static, blink, PWM), a shared prescaler, atomic set/clear and register readback.
- Sits beside data RAM in the SoC address decode; drives board LEDs directly.

Parameters:
- NUM_LED, 5, number of LED channels (1..16).
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width (>= 2*NUM_LED).
- BASE_ADDR, 32'h1000_0000, byte base address of the register window (64-byte aligned).
- PRESC_W, 24, prescaler counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  ADDR_W  byte address.
- bus_wr_en  in  1  write strobe, one word per cycle.
- bus_wdata  in  DATA_W  write data.
- bus_rd_en  in  1  read strobe.
- bus_rdata  out  DATA_W  read data.
- bus_rvalid  out  1  read data valid pulse.
- led  out  NUM_LED  LED drive, active high.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Select: access hits when bus_addr[ADDR_W-1:6] == BASE_ADDR[ADDR_W-1:6]. Offset is bus_addr[5:2]; bus_addr[1:0] is ignored.
- Register map (word offsets):
  - 0x00 OUT, NUM_LED bits, RW.
  - 0x04 MODE, 2 bits per channel, RW: 00 static, 01 blink, 10 PWM, 11 forced off.
  - 0x08 PRESC, PRESC_W bits, RW.
  - 0x0C DUTY, 8 bits, RW.
  - 0x10 SET, W1S on OUT; reads 0.
  - 0x14 CLR, W1C on OUT; reads 0.
  - 0x18 STATUS, RO: bit0 = phase, bits[15:8] = pwm_cnt.
- Writes take effect at the clk edge where bus_wr_en=1 and select hits. Unmapped offsets and non-selected addresses are ignored; upper wdata bits are ignored.
- Reads: bus_rdata and bus_rvalid are registered, valid exactly 1 cycle after bus_rd_en. bus_rvalid pulses for one cycle.
  - Unmapped or non-selected addresses still return rvalid=1 with rdata=0.
  - Unused upper bits read 0.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- SET and CLR written to the same bit in one cycle is impossible (single port). A write to OUT overrides any pending state.
- Prescaler: presc_cnt down-counts from PRESC. When presc_cnt == 0, tick=1 and presc_cnt reloads PRESC. PRESC=0 means a tick every cycle.
  - Any write to PRESC reloads presc_cnt with the new value and clears phase and pwm_cnt in the same edge.
- Blink: phase toggles on each tick. Blink period = 2*(PRESC+1) cycles.
- PWM: pwm_cnt is an 8-bit up-counter incremented on tick, wrapping 255->0. pwm_on = (pwm_cnt < DUTY).
  - DUTY=0: always off.
  - DUTY=255: on 255 of 256 ticks.
- Per-channel output, registered:
  - static: led[i] = OUT[i]
  - blink: led[i] = OUT[i] & phase
  - PWM: led[i] = OUT[i] & pwm_on
  - forced off: led[i] = 0
- led reflects a register write 1 cycle after the write edge, i.e. 2 edges after the strobe is sampled. This matches the existing register-then-pin latency.
- Reset (async assert, sync use after deassert): OUT=0, MODE=0, PRESC=0, DUTY=0, presc_cnt=0, phase=0, pwm_cnt=0, led=0, bus_rdata=0, bus_rvalid=0.
  - Reset mid-blink or mid-PWM drops led to 0 immediately, without waiting for clk.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - Offset constants: OFS_OUT, OFS_MODE, OFS_PRESC, OFS_DUTY, OFS_SET, OFS_CLR, OFS_STATUS.
  - Mode encodings: MODE_STATIC, MODE_BLINK, MODE_PWM, MODE_OFF.
- One sub-module, led_tick_gen: prescaler, phase and pwm_cnt. Inputs: presc, reload. Outputs: tick, phase, pwm_cnt.
- Register file and output mux stay in the top.

Test Plan:
1. Reset, then write OUT=0x15 (MODE=0) at BASE+0x00 -> led=5'h15 two edges after the strobe; read BASE+0x00 -> rvalid next cycle, rdata=0x15.
2. OUT=0x1F, MODE=0x1 (ch0 blink), PRESC=3 -> led[0] toggles every 4 cycles (period 8); led[4:1]=4'hF constant; STATUS bit0 tracks phase.
3. MODE=0x2 (ch0 PWM), PRESC=0, DUTY=64 -> over 256 cycles led[0] high exactly 64 cycles; DUTY=0 -> never high.
4. OUT=0x00, write SET=0x06, then CLR=0x02 -> OUT reads 0x04; SET and CLR read back 0.
5. Write to BASE+0x3C and to BASE+0x40 -> no register changes; reads return rvalid=1, rdata=0.
6. Blinking with PRESC=3, assert rst_n=0 between edges -> led=0 immediately; after release led stays 0 and all registers read 0.
